// File: rtl/ser_tx.sv
// rtl/ser_tx.sv - start/data/stop serial transmitter with per-data-bit strobe
// Frame is start(0), N data bits LSB first, stop(1); each bit lasts DIV clocks.

module ser_tx #(
  parameter int N   = 8,
  parameter int DIV = 4
) (
  input  logic         clk,
  input  logic         r,
  input  logic         start,
  input  logic [N-1:0] data,
  output logic         sd,
  output logic         sen,
  output logic         busy,
  output logic         done
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(N - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t         state_q;
  logic [CW-1:0]  cnt_q;
  logic [IW-1:0]  idx_q;
  logic [N-1:0]   sh_q;
  logic           done_q;

  logic           bit_end;
  assign bit_end = (cnt_q == CNT_MAX);

  always_ff @(posedge clk) begin
    if (r) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            sh_q    <= data;
            cnt_q   <= '0;
            idx_q   <= '0;
            state_q <= START;
          end
        end
        START: begin
          if (bit_end) begin
            cnt_q   <= '0;
            state_q <= DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            sh_q  <= sh_q >> 1;
            cnt_q <= '0;
            if (idx_q == IDX_MAX) begin
              state_q <= STOP;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            cnt_q   <= '0;
            state_q <= IDLE;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Strobe sits in the last cycle of a data bit so sd has been stable for DIV-1 cycles.
  assign sd   = (state_q == START) ? 1'b0 : (state_q == DATA) ? sh_q[0] : 1'b1;
  assign sen  = (state_q == DATA) && bit_end;
  assign busy = (state_q != IDLE);
  assign done = done_q;

endmodule
